// File: rtl/cmd_bus_arbiter_if.sv
// rtl/cmd_bus_arbiter_if.sv - requester/downstream bundle for the command link arbiter
interface cmd_bus_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ack;
    logic                  out_valid;
    logic [31:0]           out_data;
    logic [SRC_W-1:0]      out_src;
    logic                  out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ack, out_valid, out_data, out_src
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ack, out_valid, out_data, out_src
    );
endinterface

// File: rtl/cmd_bus_arbiter.sv
// rtl/cmd_bus_arbiter.sv - round-robin command link arbiter with a drop-on-stall watchdog
module cmd_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SRC_W          = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    cmd_bus_arbiter_if.slave    bus,
    output logic                timeout_err,
    output logic [7:0]          timeout_count
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SRC_W-1:0] SRC_MAX = SRC_W'(NUM_REQ - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
    logic               timeout_err_q, timeout_err_d;
    logic [7:0]         timeout_count_q, timeout_count_d;

    logic               grant_found;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand;
    logic [31:0]        grant_data;

    // Walk upward from the requester after the last winner, wrapping at NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = last_grant_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (cand == SRC_MAX) begin
                cand = '0;
            end else begin
                cand = cand + 1'b1;
            end
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                grant_data = bus.req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        wdog_d          = wdog_q;
        out_valid_d     = out_valid_q;
        out_data_d      = out_data_q;
        out_src_d       = out_src_q;
        req_ack_d       = '0;
        timeout_err_d   = 1'b0;
        timeout_count_d = timeout_count_q;
        case (state_q)
            IDLE: begin
                if (enable && grant_found) begin
                    state_d     = SEND;
                    out_data_d  = grant_data;
                    out_src_d   = grant_idx;
                    out_valid_d = 1'b1;
                    req_ack_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
                    wdog_d      = '0;
                end
            end
            SEND: begin
                // A ready in the final watchdog cycle still counts as a delivery.
                if (bus.out_ready) begin
                    out_valid_d  = 1'b0;
                    last_grant_d = out_src_q;
                    state_d      = IDLE;
                end else if (wdog_q == WD_LAST) begin
                    out_valid_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    if (timeout_count_q != 8'hFF) begin
                        timeout_count_d = timeout_count_q + 8'd1;
                    end
                    last_grant_d = out_src_q;
                    state_d      = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            last_grant_q    <= SRC_MAX;
            wdog_q          <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_src_q       <= '0;
            req_ack_q       <= '0;
            timeout_err_q   <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            wdog_q          <= wdog_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_src_q       <= out_src_d;
            req_ack_q       <= req_ack_d;
            timeout_err_q   <= timeout_err_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign bus.req_ack    = req_ack_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign timeout_err    = timeout_err_q;
    assign timeout_count  = timeout_count_q;

endmodule

// File: tb/tb_cmd_bus_arbiter.sv
// tb/tb_cmd_bus_arbiter.sv - scoreboard bench for the command link arbiter
module tb_cmd_bus_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       timeout_err;
    logic [7:0] timeout_count;

    cmd_bus_arbiter_if #(.NUM_REQ(NREQ)) bus ();

    cmd_bus_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .bus           (bus.slave),
        .timeout_err   (timeout_err),
        .timeout_count (timeout_count)
    );

    typedef struct {
        int          src;
        logic [31:0] data;
        int          gap;
    } grant_t;

    typedef struct {
        int cnt;
        int delay;
    } tmo_t;

    grant_t exp_q[$];
    tmo_t   tmo_q[$];
    int     checks;
    int     errors;
    int     cyc;
    int     last_ack_cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] dval(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    initial begin
        grant_t e;
        tmo_t   t;
        last_ack_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.req_ack != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_ack", 32'(bus.req_ack), 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ack_onehot", 32'(bus.req_ack), 32'h1 << e.src);
                        chk("grant_src", 32'(bus.out_src), 32'(e.src));
                        chk("grant_data", bus.out_data, e.data);
                        chk("grant_valid", 32'(bus.out_valid), 32'h1);
                        if (e.gap >= 0) chk("grant_gap", 32'(cyc - last_ack_cyc), 32'(e.gap));
                    end
                    last_ack_cyc = cyc;
                end
                if (timeout_err) begin
                    if (tmo_q.size() == 0) begin
                        chk("unexpected_timeout", 32'(timeout_err), 32'h0);
                    end else begin
                        t = tmo_q.pop_front();
                        chk("timeout_count", 32'(timeout_count), 32'(t.cnt));
                        chk("timeout_delay", 32'(cyc - last_ack_cyc), 32'(t.delay));
                        chk("timeout_valid_low", 32'(bus.out_valid), 32'h0);
                    end
                end
            end
        end
    end

    task automatic wait_ack(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.req_ack == '0 && n < 40);
        chk(name, 32'(bus.req_ack != '0), 32'h1);
    endtask

    task automatic wait_tmo(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 40);
        chk(name, 32'(timeout_err), 32'h1);
    endtask

    task automatic push_grant(input int src, input logic [31:0] data, input int gap);
        grant_t g;
        g.src  = src;
        g.data = data;
        g.gap  = gap;
        exp_q.push_back(g);
    endtask

    initial begin
        tmo_t t;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        enable = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) bus.req_data[32*i +: 32] = dval(i);
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_src", 32'(bus.out_src), 32'h0);
        chk("rst_req_ack", 32'(bus.req_ack), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_timeout_count", 32'(timeout_count), 32'h0);

        // round robin from reset, one word every two cycles
        rst_n = 1'b1;
        enable = 1'b1;
        bus.out_ready = 1'b1;
        push_grant(0, dval(0), -1);
        push_grant(1, dval(1), 2);
        push_grant(2, dval(2), 2);
        push_grant(3, dval(3), 2);
        push_grant(0, dval(0), 2);
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) wait_ack("rr_ack_seen");
        bus.req_valid = '0;
        repeat (2) @(negedge clk);

        // latch and hold under backpressure
        bus.out_ready = 1'b0;
        bus.req_data[32*2 +: 32] = 32'hDEAD_BEEF;
        push_grant(2, 32'hDEAD_BEEF, -1);
        bus.req_valid = 4'b0100;
        wait_ack("latch_ack_seen");
        bus.req_valid = '0;
        for (int c = 1; c <= 6; c++) begin
            chk("hold_valid", 32'(bus.out_valid), 32'h1);
            chk("hold_data", bus.out_data, 32'hDEAD_BEEF);
            chk("hold_src", 32'(bus.out_src), 32'h2);
            if (c == 6) bus.out_ready = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        chk("hold_delivered", 32'(bus.out_valid), 32'h0);
        chk("hold_no_timeout", 32'(timeout_count), 32'h0);
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // watchdog drop, then round robin continues past the dropped requester
        push_grant(1, dval(1), -1);
        t.cnt = 1;
        t.delay = TMO;
        tmo_q.push_back(t);
        bus.req_valid = 4'b0010;
        wait_ack("tmo_ack_seen");
        bus.req_valid = '0;
        wait_tmo("tmo_fired");
        @(negedge clk);
        chk("tmo_pulse_width", 32'(timeout_err), 32'h0);
        chk("tmo_count_after", 32'(timeout_count), 32'h1);
        push_grant(0, dval(0), -1);
        push_grant(1, dval(1), 2);
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b0011;
        wait_ack("rr2_ack0_seen");
        bus.req_valid[0] = 1'b0;
        wait_ack("rr2_ack1_seen");
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        @(negedge clk);

        // ready arriving in the last watchdog cycle wins over the timeout
        bus.req_data[32*3 +: 32] = 32'hCAFE_F00D;
        push_grant(3, 32'hCAFE_F00D, -1);
        bus.req_valid = 4'b1000;
        wait_ack("race_ack_seen");
        bus.req_valid = '0;
        for (int c = 2; c <= TMO; c++) @(negedge clk);
        chk("race_pre_valid", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("race_delivered", 32'(bus.out_valid), 32'h0);
        chk("race_no_err", 32'(timeout_err), 32'h0);
        chk("race_count", 32'(timeout_count), 32'h1);

        // enable low blocks grants
        enable = 1'b0;
        bus.req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("dis_no_ack", 32'(bus.req_ack), 32'h0);
            chk("dis_no_valid", 32'(bus.out_valid), 32'h0);
        end
        push_grant(0, dval(0), -1);
        push_grant(1, dval(1), 2);
        enable = 1'b1;
        wait_ack("en_ack0_seen");
        bus.req_valid[0] = 1'b0;
        wait_ack("en_ack1_seen");
        bus.req_valid[1] = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // asynchronous reset mid-SEND
        chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("arst_out_data", bus.out_data, 32'h0);
        chk("arst_out_src", 32'(bus.out_src), 32'h0);
        chk("arst_req_ack", 32'(bus.req_ack), 32'h0);
        chk("arst_timeout_err", 32'(timeout_err), 32'h0);
        chk("arst_timeout_count", 32'(timeout_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        push_grant(0, dval(0), -1);
        bus.req_valid = 4'b1111;
        wait_ack("post_rst_ack_seen");
        bus.req_valid = '0;
        repeat (3) @(negedge clk);

        chk("grants_outstanding", 32'(exp_q.size()), 32'h0);
        chk("timeouts_outstanding", 32'(tmo_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit actual=expired required=done");
        $fatal(1);
    end

endmodule
